// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable limit, parallel load, wrap/saturate
// selection, terminal-count output, boundary-event pulse and sticky over/underflow flags.
module updown_counter_param #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat_mode,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap_pulse,
    output logic             ovf_sticky,
    output logic             udf_sticky
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] nxt;
    logic             up_evt;
    logic             dn_evt;

    always_comb begin
        nxt    = out;
        up_evt = 1'b0;
        dn_evt = 1'b0;
        if (load) begin
            nxt = (load_val > limit) ? limit : load_val;
        end else if (en) begin
            // A runtime-lowered limit pulls the count back in range without an event
            if (out > limit) begin
                nxt = limit;
            end else if (up_down) begin
                if (out == limit) begin
                    up_evt = 1'b1;
                    nxt    = sat_mode ? limit : '0;
                end else begin
                    nxt = out + ONE;
                end
            end else begin
                if (out == '0) begin
                    dn_evt = 1'b1;
                    nxt    = sat_mode ? '0 : limit;
                end else begin
                    nxt = out - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out        <= RST;
            wrap_pulse <= 1'b0;
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
        end else begin
            out        <= nxt;
            wrap_pulse <= up_evt | dn_evt;
            // A new event beats a simultaneous clear
            ovf_sticky <= up_evt | (ovf_sticky & ~clear_flags);
            udf_sticky <= dn_evt | (udf_sticky & ~clear_flags);
        end
    end

    assign tc = (up_down && (out == limit)) || (!up_down && (out == '0));

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param (WIDTH=8): directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against an arithmetic reference model.
module tb_updown_counter_param;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic         up_down = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] limit = '0;
    logic         sat_mode = 1'b0;
    logic         clear_flags = 1'b0;
    logic [W-1:0] out;
    logic         tc;
    logic         wrap_pulse;
    logic         ovf_sticky;
    logic         udf_sticky;

    updown_counter_param #(.WIDTH(W), .RESET_VAL(0)) dut (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .limit(limit), .sat_mode(sat_mode),
        .clear_flags(clear_flags), .out(out), .tc(tc), .wrap_pulse(wrap_pulse),
        .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: plain integer arithmetic on the behavioural rules
    int m_out = 0;
    int m_wp = 0;
    int m_ovf = 0;
    int m_udf = 0;

    always @(posedge clk) begin
        int lim, n, up_ev, dn_ev;
        lim = int'(limit);
        up_ev = 0;
        dn_ev = 0;
        if (reset) begin
            m_out = 0; m_wp = 0; m_ovf = 0; m_udf = 0;
        end else begin
            if (load) begin
                m_out = (int'(load_val) < lim) ? int'(load_val) : lim;
            end else if (en) begin
                if (m_out > lim) m_out = lim;
                else if (up_down) begin
                    n = m_out + 1;
                    if (n > lim) begin up_ev = 1; n = sat_mode ? lim : 0; end
                    m_out = n;
                end else begin
                    n = m_out - 1;
                    if (n < 0) begin dn_ev = 1; n = sat_mode ? 0 : lim; end
                    m_out = n;
                end
            end
            m_wp = up_ev | dn_ev;
            m_ovf = up_ev ? 1 : (clear_flags ? 0 : m_ovf);
            m_udf = dn_ev ? 1 : (clear_flags ? 0 : m_udf);
        end
    end

    // Compare process, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            int m_tc;
            m_tc = (up_down && m_out == int'(limit)) || (!up_down && m_out == 0);
            check("model_out", int'(out), m_out);
            check("model_tc", int'(tc), m_tc);
            check("model_wrap_pulse", int'(wrap_pulse), m_wp);
            check("model_ovf", int'(ovf_sticky), m_ovf);
            check("model_udf", int'(udf_sticky), m_udf);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp1 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int exp2 [4]  = '{1, 0, 0, 0};
        int wp_cnt;

        reset = 1'b1;
        cyc(); cyc();
        check("reset_out", int'(out), 0);
        check("reset_wp", int'(wrap_pulse), 0);
        check("reset_ovf", int'(ovf_sticky), 0);
        check("reset_udf", int'(udf_sticky), 0);
        chk_en = 1'b1;

        // 1: wrap up through limit=9
        reset = 1'b0; limit = 8'd9; sat_mode = 1'b0; up_down = 1'b1; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            check("s1_out", int'(out), exp1[i]);
            if (i == 8) check("s1_tc_at_9", int'(tc), 1);
            if (i == 9) check("s1_wp_after_wrap", int'(wrap_pulse), 1);
            if (i == 10) check("s1_wp_drop", int'(wrap_pulse), 0);
        end
        check("s1_ovf", int'(ovf_sticky), 1);

        // 2: saturate down from 2
        up_down = 1'b0; sat_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("s2_out", int'(out), exp2[i]);
            if (i >= 2) check("s2_wp", int'(wrap_pulse), 1);
        end
        check("s2_udf", int'(udf_sticky), 1);
        check("s2_tc", int'(tc), 1);

        // 3: clamped load, then load beats count
        en = 1'b0; clear_flags = 1'b1; cyc(); clear_flags = 1'b0;
        load = 1'b1; load_val = 8'd200; limit = 8'd50;
        cyc();
        check("s3_clamp", int'(out), 50);
        check("s3_no_ovf", int'(ovf_sticky), 0);
        check("s3_no_udf", int'(udf_sticky), 0);
        load_val = 8'd7; en = 1'b1; up_down = 1'b1;
        cyc();
        check("s3_load_en", int'(out), 7);
        check("s3_no_wp", int'(wrap_pulse), 0);

        // 4: limit lowered below count
        load_val = 8'd35; en = 1'b0; cyc();
        load = 1'b0; en = 1'b1;
        repeat (5) cyc();
        check("s4_at_40", int'(out), 40);
        limit = 8'd20;
        cyc();
        check("s4_pull_in", int'(out), 20);
        check("s4_no_wp", int'(wrap_pulse), 0);
        check("s4_no_ovf", int'(ovf_sticky), 0);
        limit = 8'd50; load = 1'b1; load_val = 8'd40; en = 1'b0; cyc();
        load = 1'b0; limit = 8'd20;
        cyc(); cyc();
        check("s4_hold", int'(out), 40);

        // 5: set beats clear, then clear
        limit = 8'd9; load = 1'b1; load_val = 8'd9; cyc();
        load = 1'b0; en = 1'b1; up_down = 1'b1; sat_mode = 1'b0; clear_flags = 1'b1;
        cyc();
        check("s5_set_wins", int'(ovf_sticky), 1);
        en = 1'b0;
        cyc();
        check("s5_clr_ovf", int'(ovf_sticky), 0);
        check("s5_clr_udf", int'(udf_sticky), 0);
        clear_flags = 1'b0;

        // 6: reset mid-count, then full-range wrap
        load = 1'b1; load_val = 8'd3; cyc();
        load = 1'b0; en = 1'b1;
        cyc(); cyc();
        check("s6_at_5", int'(out), 5);
        reset = 1'b1;
        cyc();
        check("s6_rst_out", int'(out), 0);
        check("s6_rst_ovf", int'(ovf_sticky), 0);
        reset = 1'b0; limit = 8'd255; wp_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            cyc();
            if (wrap_pulse) wp_cnt++;
        end
        check("s6_full_wrap_out", int'(out), 0);
        check("s6_one_event", wp_cnt, 1);
        check("s6_ovf", int'(ovf_sticky), 1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 149) == 0);
            load = ($urandom_range(0, 11) == 0);
            load_val = 8'($urandom_range(0, 255));
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) up_down = ~up_down;
            if ($urandom_range(0, 31) == 0) sat_mode = ~sat_mode;
            clear_flags = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 4))
                    0: limit = 8'd0;
                    1: limit = 8'd1;
                    2: limit = 8'd255;
                    3: limit = 8'($urandom_range(2, 15));
                    default: limit = 8'($urandom_range(0, 255));
                endcase
            end
            cyc();
        end

        chk_en = 1'b0;
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised up/down counter, the next generation of the team's fixed-width counter. Adds:
- generic width and programmable terminal value (limit);
- count enable and parallel load;
- wrap or saturate selection at both ends;
- terminal-count indication, boundary-event pulse and sticky overflow/underflow flags.

Used as a general event/position counter in datapath and control blocks. Replaces ad-hoc fixed-width counters.

Parameters:
WIDTH, 16, counter width in bits (legal range 2..32).
RESET_VAL, 0, value loaded into out on reset; must be <= 2**WIDTH-1.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  count enable; no count when low.
up_down  input  1  1 = count up, 0 = count down.
load  input  1  parallel load strobe.
load_val  input  WIDTH  value for parallel load.
limit  input  WIDTH  inclusive upper bound of count range 0..limit; sampled every cycle.
sat_mode  input  1  0 = wrap at ends, 1 = saturate at ends.
clear_flags  input  1  clears ovf_sticky and udf_sticky.
out  output  WIDTH  registered count value.
tc  output  1  combinational terminal count: (up_down && out==limit) || (!up_down && out==0).
wrap_pulse  output  1  registered; high for exactly one cycle after any boundary event.
ovf_sticky  output  1  registered; set by an up boundary event.
udf_sticky  output  1  registered; set by a down boundary event.

Behaviour:
- Reset values: out=RESET_VAL, wrap_pulse=0, ovf_sticky=0, udf_sticky=0. Reset overrides every other input. Reset mid-count discards all pending events.
- Priority each cycle: reset > load > en.
- Load: out <= min(load_val, limit). A clamped load sets no flag. Load with en=1 in the same cycle performs the load only, with no count and no event.
- Enabled count, out within range:
  - Up, out < limit: out <= out+1.
  - Up, out == limit: up boundary event. out <= 0 if sat_mode=0; out <= limit if sat_mode=1.
  - Down, out > 0: out <= out-1.
  - Down, out == 0: down boundary event. out <= limit if sat_mode=0; out <= 0 if sat_mode=1.
- Enabled count with out > limit (limit lowered at runtime): out <= limit regardless of direction. Not a boundary event; no flags.
- en=0 and load=0: out holds. No events, even if out > limit.
- limit=0: range is {0}.
  - Every enabled count is a boundary event; out stays 0.
  - tc is 1 in both directions.
- Boundary events are generated in saturate mode as well. A saturated attempt counts as an event every enabled cycle at the end.
- wrap_pulse: registered version of (up event OR down event). Latency 1 cycle. A continuous event stream gives a continuous high level.
- Sticky flags:
  - ovf_sticky <= 1 on an up event; udf_sticky <= 1 on a down event.
  - Otherwise a flag clears when clear_flags=1, else holds.
  - Set and clear_flags in the same cycle: set wins.
- All arithmetic is modulo 2**WIDTH with no carry out. limit = 2**WIDTH-1 gives natural full-range wrap.
- tc depends only on out, limit and up_down. It is independent of en, load and sat_mode.

Test Plan:
All scenarios use WIDTH=8, RESET_VAL=0.
1. Reset, then limit=9, sat_mode=0, up=1, en=1 for 12 cycles -> out 1..9,0,1,2. tc=1 while out=9. wrap_pulse high the cycle after 9->0. ovf_sticky=1 from then on.
2. limit=9, down, sat_mode=1 from out=2 for 4 cycles -> out 1,0,0,0. udf_sticky set. wrap_pulse high two consecutive cycles. tc=1 while out=0.
3. Load with load_val=200, limit=50 -> out=50, no flags. Then load=1 and en=1 together with load_val=7 -> out=7, no count.
4. Count up to out=40, drop limit to 20, en=1 -> out=20 next cycle, no flags. With en=0 instead -> out holds at 40.
5. Up event coincident with clear_flags=1 -> ovf_sticky=1. Next cycle clear_flags=1 with no event -> ovf_sticky=0, udf_sticky=0.
6. Assert reset mid-count at out=5 with en=1 -> out=0 and all flags 0 next cycle. Then limit=255, up 256 cycles -> full wrap 255->0 with one ovf event.
